// File: rtl/fnd_scan_ctrl_if.sv
// rtl/fnd_scan_ctrl_if.sv - Digit load/control inputs and multiplexed display bus of the scan driver
interface fnd_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] digit_val;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  fnd;
  logic        fnd_dp;
  logic        fndsel1;
  logic        fndsel2;
  logic        fndsel3;
  logic        fndsel4;

  modport master (
    output en, load, digit_val, dp_in, blank_lz,
    input  fnd, fnd_dp, fndsel1, fndsel2, fndsel3, fndsel4
  );

  modport slave (
    input  en, load, digit_val, dp_in, blank_lz,
    output fnd, fnd_dp, fndsel1, fndsel2, fndsel3, fndsel4
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - Tear-free 4-digit active-low 7-segment scan driver with gap and zero blanking
module fnd_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_GAP = 2000
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);
  localparam int CNT_MAX = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] div_cnt;
  logic [15:0]   pending, shadow;
  logic [3:0]    pend_dp, shadow_dp;
  logic          pend_valid;
  logic [6:0]    fnd_r;
  logic          fnd_dp_r;
  logic [3:0]    sel_r;

  logic          go_show, take, lz;
  logic [1:0]    show_idx;
  logic [15:0]   sh_next;
  logic [3:0]    dp_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  // Digit shown after this edge, decoded from the shadow value that will be current then
  always_comb begin
    go_show = 1'b0;
    case (state)
      IDLE:    go_show = 1'b1;
      SHOW:    go_show = (div_cnt == DIV_LAST) && (BLANK_GAP == 0);
      GAP:     go_show = (div_cnt == GAP_LAST);
      default: go_show = 1'b0;
    endcase
    go_show  = go_show && bus.en;
    show_idx = (state == IDLE) ? 2'd0 : idx + 2'd1;
    take     = go_show && (show_idx == 2'd0) && pend_valid;
    sh_next  = take ? pending : shadow;
    dp_next  = take ? pend_dp : shadow_dp;
    lz       = bus.blank_lz && (show_idx != 2'd0);
    for (int j = 1; j < 4; j++) begin
      if (2'(j) >= show_idx && sh_next[4*j +: 4] != 4'd0) lz = 1'b0;
    end
    seg_next = lz ? 7'h7F : hex_seg(sh_next[{show_idx, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      div_cnt    <= '0;
      pending    <= 16'd0;
      pend_dp    <= 4'd0;
      shadow     <= 16'd0;
      shadow_dp  <= 4'd0;
      pend_valid <= 1'b0;
      fnd_r      <= 7'h7F;
      fnd_dp_r   <= 1'b1;
      sel_r      <= 4'hF;
    end else begin
      if (take) begin
        shadow     <= pending;
        shadow_dp  <= pend_dp;
        pend_valid <= 1'b0;
      end
      // A load coinciding with the transfer lands in pending and keeps it valid
      if (bus.load) begin
        pending    <= bus.digit_val;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end
      if (!bus.en) begin
        state    <= IDLE;
        idx      <= 2'd0;
        div_cnt  <= '0;
        fnd_r    <= 7'h7F;
        fnd_dp_r <= 1'b1;
        sel_r    <= 4'hF;
      end else if (go_show) begin
        state    <= SHOW;
        idx      <= show_idx;
        div_cnt  <= '0;
        fnd_r    <= seg_next;
        fnd_dp_r <= ~dp_next[show_idx];
        sel_r    <= ~(4'b0001 << show_idx);
      end else if (state == SHOW && div_cnt == DIV_LAST) begin
        state    <= GAP;
        div_cnt  <= '0;
        fnd_r    <= 7'h7F;
        fnd_dp_r <= 1'b1;
        sel_r    <= 4'hF;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
    end
  end

  assign bus.fnd     = fnd_r;
  assign bus.fnd_dp  = fnd_dp_r;
  assign bus.fndsel1 = sel_r[0];
  assign bus.fndsel2 = sel_r[1];
  assign bus.fndsel3 = sel_r[2];
  assign bus.fndsel4 = sel_r[3];
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - Self-checking bench for fnd_scan_ctrl with slot/frame arithmetic reference model
module tb_fnd_scan_ctrl;
  localparam int SD    = 4;
  localparam int BG    = 1;
  localparam int SLOT  = SD + BG;
  localparam int FRAME = 4 * SLOT;
  localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

  logic clk = 1'b0;
  logic reset;
  fnd_scan_ctrl_if bus();

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_GAP(BG)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: s counts edges since scanning started; slot and frame position follow by division
  int          s;
  logic [15:0] m_pend, m_shad;
  logic [3:0]  m_pdp, m_sdp;
  logic        m_pv;
  logic [3:0]  e_sel;
  logic [6:0]  e_fnd;
  logic        e_dp;

  typedef struct {
    logic [15:0]      dv;
    logic [3:0]       dp;
    logic             blz;
    logic [3:0][6:0]  segs;
    logic [3:0]       dpn;
  } vec_t;
  vec_t vt [5];

  task automatic model_blank();
    e_sel = 4'hF; e_fnd = 7'h7F; e_dp = 1'b1;
  endtask

  task automatic model_reset();
    s = -1; m_pend = 16'd0; m_shad = 16'd0; m_pdp = 4'd0; m_sdp = 4'd0; m_pv = 1'b0;
    model_blank();
  endtask

  task automatic model_clock();
    int k, ph;
    logic [3:0] nib;
    logic [3:0] one;
    if (reset) begin
      model_reset();
      return;
    end
    if (!bus.en) begin
      s = -1;
      model_blank();
    end else begin
      s++;
      if (s % FRAME == 0 && m_pv) begin
        m_shad = m_pend; m_sdp = m_pdp; m_pv = 1'b0;
      end
      k  = (s / SLOT) % 4;
      ph = s % SLOT;
      if (ph == SD) model_blank();
      else if (ph == 0) begin
        one   = 4'b0001 << k;
        e_sel = ~one;
        nib   = 4'((m_shad >> (4 * k)) & 16'hF);
        e_fnd = (bus.blank_lz && k > 0 && (m_shad >> (4 * k)) == 16'd0) ? 7'h7F : seg_tab[nib];
        e_dp  = ~m_sdp[k];
      end
    end
    if (bus.load) begin
      m_pend = bus.digit_val; m_pdp = bus.dp_in; m_pv = 1'b1;
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.fndsel4, bus.fndsel3, bus.fndsel2, bus.fndsel1, bus.fnd, bus.fnd_dp};
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at s=%0d: sel=%b fnd=%b dp=%b, expected sel=%b fnd=%b dp=%b",
               name, s, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check(name, dut_out(), {e_sel, e_fnd, e_dp});
  endtask

  task automatic run_until(input int tgt, input int md);
    for (int n = 0; n < 200 && !(s >= 0 && s % md == tgt); n++) tick("run");
    if (!(s >= 0 && s % md == tgt)) check_int("run_until_timeout", s, tgt);
  endtask

  task automatic restart_with(input logic [15:0] dv, input logic [3:0] dp, input logic blz);
    bus.en = 1'b0; bus.load = 1'b1; bus.digit_val = dv; bus.dp_in = dp; bus.blank_lz = blz;
    tick("restart_idle");
    bus.load = 1'b0; bus.en = 1'b1;
  endtask

  initial begin
    logic [11:0] exp;
    logic [3:0]  one;
    int          seen7;

    vt[0] = '{16'h1A38, 4'b0000, 1'b0, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0000000}, 4'b1111};
    vt[1] = '{16'h0005, 4'b0100, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1011};
    vt[2] = '{16'h2222, 4'b0000, 1'b0, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111};
    vt[3] = '{16'h0000, 4'b1001, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0110};
    vt[4] = '{16'hF0C0, 4'b0010, 1'b1, {7'b0001110, 7'b1000000, 7'b1000110, 7'b1000000}, 4'b1101};

    reset = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.digit_val = 16'd0; bus.dp_in = 4'd0; bus.blank_lz = 1'b0;
    model_reset();
    tick("reset_hold");
    check("reset_state", dut_out(), BLANK);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      restart_with(vt[i].dv, vt[i].dp, vt[i].blz);
      for (int c = 0; c < FRAME; c++) begin
        tick("tbl_model");
        if (c % SLOT == SD) exp = BLANK;
        else begin
          one = 4'b0001 << (c / SLOT);
          exp = {~one, vt[i].segs[c / SLOT], vt[i].dpn[c / SLOT]};
        end
        check("tbl_vec", dut_out(), exp);
      end
    end

    run_until(1, SLOT);
    reset = 1'b1;
    #1;
    check("reset_async", dut_out(), BLANK);
    model_reset();
    tick("reset_held");
    reset = 1'b0;
    restart_with(16'h0003, 4'b0000, 1'b0);
    tick("reset_first");
    check("reset_first_show", dut_out(), {4'b1110, 7'b0110000, 1'b1});

    restart_with(16'h2222, 4'b0000, 1'b0);
    run_until(10, FRAME);
    bus.load = 1'b1; bus.digit_val = 16'h1111;
    tick("mid_load");
    bus.load = 1'b0;
    run_until(15, FRAME);
    check("tear_free_d3", dut_out(), {4'b0111, 7'b0100100, 1'b1});
    run_until(0, FRAME);
    check("new_frame_d0", dut_out(), {4'b1110, 7'b1111001, 1'b1});
    run_until(15, FRAME);
    check("new_frame_d3", dut_out(), {4'b0111, 7'b1111001, 1'b1});

    run_until(2, FRAME);
    bus.load = 1'b1; bus.digit_val = 16'h0007;
    tick("load7");
    run_until(10, FRAME);
    bus.digit_val = 16'h0008;
    tick("load8");
    bus.load = 1'b0;
    run_until(0, FRAME);
    check("last_load_wins", dut_out(), {4'b1110, 7'b0000000, 1'b1});
    seen7 = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick("frame8");
      if (bus.fnd == 7'b1111000) seen7++;
    end
    check_int("seven_never_shown", seen7, 0);

    run_until(SD, SLOT);
    check("in_gap", dut_out(), BLANK);
    bus.en = 1'b0;
    tick("en_drop");
    check("en_drop_idle", dut_out(), BLANK);
    bus.en = 1'b1;
    tick("en_raise");
    check("en_restart", dut_out(), {4'b1110, 7'b0000000, 1'b1});

    for (int c = 0; c < 1500; c++) begin
      bus.en   = ($urandom_range(0, 99) != 0);
      bus.load = ($urandom_range(0, 29) == 0);
      bus.digit_val = 16'($urandom);
      bus.dp_in     = 4'($urandom);
      if ($urandom_range(0, 149) == 0) bus.blank_lz = ~bus.blank_lz;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
